fc_seq_ctrl: RTL and testbench

- Sequencer for the fully-connected MAC datapath: x vector memory, W ROM, saturating accumulator and ReLU output register.
- Accepts an N-element input vector over a valid/ready stream and writes it into x memory.
- Issues M×N address pairs to x memory and the W ROM, and drives accumulator enables aligned to the datapath read/multiply latency.
- Presents each of the M row results on a valid/ready output stream, then returns to loading the next vector.

---
 rtl/fc_seq_if.sv | 50 +++++
 rtl/fc_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_fc_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_seq_if.sv
// Handshake and address bundle between the FC sequencer and its datapath/stream peers.
// master = sequencer side, slave = source/sink/datapath side.
interface fc_seq_if #(
  parameter int unsigned M = 4,
  parameter int unsigned N = 4
);
  localparam int unsigned LOGN = $clog2(N);
  localparam int unsigned LOGW = $clog2(M * N);
  localparam int unsigned ROWW = $clog2(M) + 1;

  logic            input_valid;
  logic            input_ready;
  logic            wr_en_x;
  logic [LOGN-1:0] addr_x;
  logic [LOGW-1:0] addr_w;
  logic            en_acc;
  logic            acc_load;
  logic            output_valid;
  logic            output_ready;
  logic [ROWW-1:0] row_idx;
  logic            busy;

  modport master (
    input  input_valid,
    input  output_ready,
    output input_ready,
    output wr_en_x,
    output addr_x,
    output addr_w,
    output en_acc,
    output acc_load,
    output output_valid,
    output row_idx,
    output busy
  );

  modport slave (
    output input_valid,
    output output_ready,
    input  input_ready,
    input  wr_en_x,
    input  addr_x,
    input  addr_w,
    input  en_acc,
    input  acc_load,
    input  output_valid,
    input  row_idx,
    input  busy
  );
endinterface

// File: rtl/fc_seq_ctrl.sv
// Sequencer for the fully-connected MAC datapath: loads an N-element x vector,
// walks M rows of N columns through x memory / W ROM, aligns accumulator enables, presents rows.
module fc_seq_ctrl #(
  parameter int unsigned M   = 4,
  parameter int unsigned N   = 4,
  parameter int unsigned LAT = 2
) (
  input  logic     clk,
  input  logic     reset,
  fc_seq_if.master bus
);
  localparam int unsigned LOGN = $clog2(N);
  localparam int unsigned LOGW = $clog2(M * N);
  localparam int unsigned ROWW = $clog2(M) + 1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ISSUE,
    ST_DRAIN,
    ST_OUT
  } state_e;

  state_e          state_q, state_d;
  logic [LOGN-1:0] xcnt_q, xcnt_d;
  logic [LOGW-1:0] wcnt_q, wcnt_d;
  logic [ROWW-1:0] row_q, row_d;
  logic [LAT-1:0]  issue_sr_q, issue_sr_d;
  logic [LAT-1:0]  first_sr_q, first_sr_d;
  logic            in_rdy_q, in_rdy_d;
  logic            out_vld_q, out_vld_d;
  logic            busy_q, busy_d;

  logic            accept_c;
  logic            issue_c;
  logic            first_c;
  logic            out_hs_c;
  logic            last_col_c;
  logic            last_row_c;

  // xcnt doubles as the load count in LOAD and the column count in ISSUE.
  assign accept_c   = bus.input_valid & in_rdy_q;
  assign issue_c    = (state_q == ST_ISSUE);
  assign last_col_c = (xcnt_q == LOGN'(N - 1));
  assign last_row_c = (row_q == ROWW'(M - 1));
  assign first_c    = issue_c & (xcnt_q == '0);
  assign out_hs_c   = out_vld_q & bus.output_ready;

  // Issue/first pipelines model the read+multiply latency; bit LAT-1 lines up with the product.
  assign issue_sr_d = LAT'({issue_sr_q, issue_c});
  assign first_sr_d = LAT'({first_sr_q, first_c});

  always_comb begin
    state_d   = state_q;
    xcnt_d    = xcnt_q;
    wcnt_d    = wcnt_q;
    row_d     = row_q;
    out_vld_d = out_vld_q;

    case (state_q)
      ST_LOAD: begin
        if (accept_c) begin
          if (last_col_c) begin
            xcnt_d  = '0;
            row_d   = '0;
            state_d = ST_ISSUE;
          end else begin
            xcnt_d = xcnt_q + LOGN'(1);
          end
        end
      end

      ST_ISSUE: begin
        // W address holds at the row's last column so it stays frozen while draining/presenting.
        if (last_col_c) begin
          xcnt_d  = '0;
          state_d = ST_DRAIN;
        end else begin
          xcnt_d = xcnt_q + LOGN'(1);
          wcnt_d = wcnt_q + LOGW'(1);
        end
      end

      ST_DRAIN: begin
        // Leave once the final enable is shifting out this cycle.
        if (issue_sr_d == '0) begin
          out_vld_d = 1'b1;
          state_d   = ST_OUT;
        end
      end

      ST_OUT: begin
        if (out_hs_c) begin
          out_vld_d = 1'b0;
          if (last_row_c) begin
            row_d   = '0;
            wcnt_d  = '0;
            state_d = ST_LOAD;
          end else begin
            row_d   = row_q + ROWW'(1);
            wcnt_d  = wcnt_q + LOGW'(1);
            state_d = ST_ISSUE;
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  assign in_rdy_d = (state_d == ST_LOAD);
  assign busy_d   = (state_d != ST_LOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      xcnt_q     <= '0;
      wcnt_q     <= '0;
      row_q      <= '0;
      issue_sr_q <= '0;
      first_sr_q <= '0;
      in_rdy_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      xcnt_q     <= xcnt_d;
      wcnt_q     <= wcnt_d;
      row_q      <= row_d;
      issue_sr_q <= issue_sr_d;
      first_sr_q <= first_sr_d;
      in_rdy_q   <= in_rdy_d;
      out_vld_q  <= out_vld_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.input_ready  = in_rdy_q;
  assign bus.wr_en_x      = accept_c;
  assign bus.addr_x       = xcnt_q;
  assign bus.addr_w       = wcnt_q;
  assign bus.en_acc       = issue_sr_q[LAT-1];
  assign bus.acc_load     = first_sr_q[LAT-1];
  assign bus.output_valid = out_vld_q;
  assign bus.row_idx      = row_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Bench for fc_seq_ctrl: time-offset reference model checked every cycle, a small
// W ROM / saturating accumulator / ReLU datapath, and hand-computed row results.
module tb_fc_seq_ctrl;
  localparam int M   = 4;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic signed [7:0] in_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_seq_if #(.M(M), .N(N)) bus_if ();

  fc_seq_ctrl #(.M(M), .N(N), .LAT(LAT)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus_if)
  );

  int w_rom [M*N] = '{1, 2, 3, 4, -1, -2, -3, -4, 127, 127, 127, 127, 2, -1, 0, 5};
  int v1 [N] = '{1, 2, 3, 4};
  int v2 [N] = '{127, 127, 127, 127};
  int v3 [N] = '{5, -6, 7, -8};
  int v4 [N] = '{3, 1, 4, 1};
  int got_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  // ---------------- reference model: phase + cycle offset within a row ----------------
  bit m_loading = 1'b1;
  bit m_fresh   = 1'b1;
  int m_lc = 0, m_row = 0, m_k = 0;
  int m_x [N];

  function automatic int golden(input int r);
    int a = 0;
    for (int j = 0; j < N; j++)
      a = (j == 0) ? sat16(m_x[j] * w_rom[r*N + j]) : sat16(a + m_x[j] * w_rom[r*N + j]);
    return relu(a);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_loading <= 1'b1; m_fresh <= 1'b1; m_lc <= 0; m_row <= 0; m_k <= 0;
    end else if (m_loading) begin
      m_fresh <= 1'b0;
      if (!m_fresh && bus_if.input_valid) begin
        m_x[m_lc] <= int'(in_data);
        if (m_lc == N - 1) begin
          m_loading <= 1'b0; m_lc <= 0; m_row <= 0; m_k <= 0;
        end else begin
          m_lc <= m_lc + 1;
        end
      end
    end else if (m_k < N + LAT) begin
      m_k <= m_k + 1;
    end else if (bus_if.output_ready) begin
      if (m_row == M - 1) begin
        m_loading <= 1'b1; m_row <= 0;
      end else begin
        m_row <= m_row + 1; m_k <= 0;
      end
    end
  end

  // ---------------- datapath driven by the DUT's sampled outputs ----------------
  bit s_wr, s_en, s_ld;
  int s_ax, s_aw, s_data;
  int x_dp [N];
  int p1 = 0, p2 = 0, acc = 0;

  always @(negedge clk) begin
    s_wr   = bus_if.wr_en_x;
    s_en   = bus_if.en_acc;
    s_ld   = bus_if.acc_load;
    s_ax   = int'(bus_if.addr_x);
    s_aw   = int'(bus_if.addr_w);
    s_data = int'(in_data);
  end

  always @(posedge clk) begin
    if (s_wr) x_dp[s_ax] <= s_data;
    p1 <= x_dp[s_ax] * w_rom[s_aw];
    p2 <= p1;
    if (s_en) acc <= s_ld ? sat16(p2) : sat16(acc + p2);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    int got;
    bit exp_rdy;
    if (!rst_n) begin
      chk("rst_input_ready", int'(bus_if.input_ready), 0);
      chk("rst_output_valid", int'(bus_if.output_valid), 0);
      chk("rst_busy", int'(bus_if.busy), 0);
      chk("rst_en_acc", int'(bus_if.en_acc), 0);
    end else if (m_loading) begin
      exp_rdy = !m_fresh;
      chk("input_ready", int'(bus_if.input_ready), int'(exp_rdy));
      chk("wr_en_x", int'(bus_if.wr_en_x), int'(bus_if.input_valid & exp_rdy));
      chk("addr_x_load", int'(bus_if.addr_x), m_lc);
      chk("busy_load", int'(bus_if.busy), 0);
      chk("output_valid_load", int'(bus_if.output_valid), 0);
      chk("en_acc_load", int'(bus_if.en_acc), 0);
      chk("acc_load_load", int'(bus_if.acc_load), 0);
      chk("row_idx_load", int'(bus_if.row_idx), 0);
    end else begin
      chk("input_ready_run", int'(bus_if.input_ready), 0);
      chk("wr_en_x_run", int'(bus_if.wr_en_x), 0);
      chk("busy_run", int'(bus_if.busy), 1);
      chk("row_idx", int'(bus_if.row_idx), m_row);
      chk("output_valid", int'(bus_if.output_valid), int'(m_k >= N + LAT));
      chk("en_acc", int'(bus_if.en_acc), int'(m_k >= LAT && m_k < N + LAT));
      chk("acc_load", int'(bus_if.acc_load), int'(m_k == LAT));
      chk("addr_w", int'(bus_if.addr_w), m_row * N + ((m_k < N) ? m_k : N - 1));
      if (m_k < N) chk("addr_x_issue", int'(bus_if.addr_x), m_k);
      if (bus_if.output_valid && bus_if.output_ready) begin
        got = relu(acc);
        chk("row_value", got, golden(m_row));
        got_q.push_back(got);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_vec(input int xs [N], input bit gapped);
    int i = 0;
    int guard = 0;
    bit gap = 1'b0;
    while (i < N && guard < 400) begin
      @(posedge clk); #1;
      bus_if.input_valid = !gap;
      in_data = 8'(xs[i]);
      @(negedge clk);
      if (bus_if.input_valid && bus_if.input_ready) begin
        i++;
        gap = gapped;
      end else begin
        gap = 1'b0;
      end
      guard++;
    end
    @(posedge clk); #1;
    bus_if.input_valid = 1'b0;
    if (i < N) chk("send_timeout", i, N);
  endtask

  task automatic wait_row(input int r);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(bus_if.busy && int'(bus_if.row_idx) == r && !bus_if.output_valid) && g < 300);
    if (g >= 300) chk("wait_row_timeout", r, -1);
  endtask

  task automatic wait_outputs(input int n);
    int g = 0;
    while (got_q.size() < n && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (got_q.size() < n) chk("wait_outputs_timeout", got_q.size(), n);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int cnt;
    int g;
    int exp_vals [14] = '{30, 0, 1270, 20, 1270, 0, 32767, 762, 0, 18, 21, 0, 1143, 10};
    bus_if.input_valid  = 1'b0;
    bus_if.output_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("por_input_ready", int'(bus_if.input_ready), 0);
    chk("por_busy", int'(bus_if.busy), 0);
    chk("por_row_idx", int'(bus_if.row_idx), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_first_edge", int'(bus_if.input_ready), 0);
    @(negedge clk);
    chk("ready_after_first_edge", int'(bus_if.input_ready), 1);

    // Vector 1 streamed densely, vector 2 gapped and back-to-back behind it.
    send_vec(v1, 1'b0);
    send_vec(v2, 1'b1);

    // Stall the sink on row 1 of vector 2.
    wait_row(1);
    @(posedge clk); #1 bus_if.output_ready = 1'b0;
    cnt = 0;
    g = 0;
    while (cnt < 10 && g < 200) begin
      @(negedge clk);
      if (bus_if.output_valid) cnt++;
      g++;
    end
    chk("pause_addr_w", int'(bus_if.addr_w), 7);
    chk("pause_en_acc", int'(bus_if.en_acc), 0);
    chk("pause_valid", int'(bus_if.output_valid), 1);
    @(posedge clk); #1 bus_if.output_ready = 1'b1;
    @(negedge clk);
    chk("handshake_valid", int'(bus_if.output_valid), 1);
    @(negedge clk);
    chk("resume_addr_w", int'(bus_if.addr_w), 8);
    chk("resume_row_idx", int'(bus_if.row_idx), 2);
    chk("resume_valid", int'(bus_if.output_valid), 0);
    wait_outputs(8);

    // Vector 3 aborted by an asynchronous reset during row 2 issue.
    send_vec(v3, 1'b0);
    wait_row(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_input_ready", int'(bus_if.input_ready), 0);
    chk("async_output_valid", int'(bus_if.output_valid), 0);
    chk("async_busy", int'(bus_if.busy), 0);
    chk("async_en_acc", int'(bus_if.en_acc), 0);
    chk("async_acc_load", int'(bus_if.acc_load), 0);
    chk("async_wr_en_x", int'(bus_if.wr_en_x), 0);
    chk("async_row_idx", int'(bus_if.row_idx), 0);
    chk("async_addr_w", int'(bus_if.addr_w), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease_ready_low", int'(bus_if.input_ready), 0);
    @(negedge clk);
    chk("rerelease_ready_high", int'(bus_if.input_ready), 1);

    send_vec(v4, 1'b0);
    wait_outputs(14);
    repeat (3) @(negedge clk);

    chk("output_count", got_q.size(), 14);
    for (int i = 0; i < 14; i++) begin
      if (i < got_q.size()) chk($sformatf("row_result_%0d", i), got_q[i], exp_vals[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
